// File: rtl/action_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : action_encoder
//  Purpose  : Turns three raw, asynchronous action buttons into a registered
//             2-bit action code. Each button is synchronized and optionally
//             debounced. The filtered levels are priority encoded, and a
//             three-state FSM (IDLE / ACTIVE / COOLDOWN) presents each action
//             for a minimum time. After an action it forces an idle gap.
//
//  Ports    : clk          - single clock, rising edge
//             rst          - asynchronous, active-high reset
//             inputButtons - raw requests, bit2 highest priority, bit0 lowest
//             outputState  - registered code: 11=bit2, 10=bit1, 01=bit0, 00=none
//             changed      - one-cycle pulse when outputState takes a new
//                            non-zero code
//             busy         - high whenever the FSM is not in IDLE
//
//  Parameters: DEBOUNCE_CYCLES (1..255), HOLD_CYCLES (1..255),
//              COOLDOWN_CYCLES (1..255)
//
//  Build option: define ACTION_ENCODER_DEBOUNCE_EN to compile in the
//              per-button debounce filter. When it is undefined, the filtered
//              level is the synchronized level and DEBOUNCE_CYCLES is unused.
//
//  Revision : 1.0 - initial release
// ============================================================================
module action_encoder #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 8,
   parameter int COOLDOWN_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] inputButtons,
   output logic [1:0] outputState,
   output logic       changed,
   output logic       busy
);

   // Counters are loaded with N-1 and act when they reach zero, so an
   // 8-bit counter covers the full 1..255 parameter range.
   localparam logic [7:0] c_HOLD_LOAD = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] c_COOL_LOAD = 8'(COOLDOWN_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'b00,
      S_ACTIVE   = 2'b01,
      S_COOLDOWN = 2'b10
   } state_t;

   // ------------------------------------------------------------------
   // Elaboration-time parameter range checks
   // ------------------------------------------------------------------
   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_chk_debounce
      $error("action_encoder: DEBOUNCE_CYCLES must be in 1..255");
   end
   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_chk_hold
      $error("action_encoder: HOLD_CYCLES must be in 1..255");
   end
   if (COOLDOWN_CYCLES < 1 || COOLDOWN_CYCLES > 255) begin : g_chk_cooldown
      $error("action_encoder: COOLDOWN_CYCLES must be in 1..255");
   end

   // ------------------------------------------------------------------
   // Two-flop synchronizer on every button
   // ------------------------------------------------------------------
   logic [2:0] r_sync1;
   logic [2:0] r_sync2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 3'b000;
         r_sync2 <= 3'b000;
      end else begin
         r_sync1 <= inputButtons;
         r_sync2 <= r_sync1;
      end
   end

   // ------------------------------------------------------------------
   // Filtered button levels
   // ------------------------------------------------------------------
   logic [2:0] w_filt;

`ifdef ACTION_ENCODER_DEBOUNCE_EN
   localparam logic [7:0] c_DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

   for (genvar i = 0; i < 3; i++) begin : g_debounce
      logic [7:0] r_db_cnt;
      logic       r_db_level;

      // The counter tracks how many consecutive cycles the synchronized
      // value has disagreed with the filtered level. The level flips on
      // the DEBOUNCE_CYCLES-th disagreeing cycle. Any agreeing cycle
      // restarts the count.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_db_cnt   <= 8'd0;
            r_db_level <= 1'b0;
         end else if (r_sync2[i] == r_db_level) begin
            r_db_cnt   <= 8'd0;
         end else if (r_db_cnt == c_DB_LAST) begin
            r_db_level <= r_sync2[i];
            r_db_cnt   <= 8'd0;
         end else begin
            r_db_cnt   <= r_db_cnt + 8'd1;
         end
      end

      assign w_filt[i] = r_db_level;
   end
`else
   assign w_filt = r_sync2;
`endif

   // ------------------------------------------------------------------
   // Priority encode of the filtered levels
   // ------------------------------------------------------------------
   logic [1:0] w_req;

   always_comb begin
      w_req = 2'b00;
      if (w_filt[2]) begin
         w_req = 2'b11;
      end else if (w_filt[1]) begin
         w_req = 2'b10;
      end else if (w_filt[0]) begin
         w_req = 2'b01;
      end
   end

   // ------------------------------------------------------------------
   // Action FSM
   // A single counter serves as the hold timer in ACTIVE and as the
   // cooldown timer in COOLDOWN. The two timers are never live together.
   // ------------------------------------------------------------------
   state_t     r_state;
   state_t     w_state_nxt;
   logic [1:0] r_code;
   logic [1:0] w_code_nxt;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_nxt;
   logic       r_changed;
   logic       w_changed_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_code    <= 2'b00;
         r_cnt     <= 8'd0;
         r_changed <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_code    <= w_code_nxt;
         r_cnt     <= w_cnt_nxt;
         r_changed <= w_changed_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_code_nxt    = r_code;
      w_cnt_nxt     = r_cnt;
      w_changed_nxt = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_code_nxt = 2'b00;
            if (w_req != 2'b00) begin
               w_state_nxt   = S_ACTIVE;
               w_code_nxt    = w_req;
               w_cnt_nxt     = c_HOLD_LOAD;
               w_changed_nxt = 1'b1;
            end
         end

         S_ACTIVE: begin
            if (r_cnt != 8'd0) begin
               // Minimum hold not yet met, so no request may preempt.
               w_cnt_nxt = r_cnt - 8'd1;
            end else if (w_req != r_code) begin
               if (w_req != 2'b00) begin
                  // Direct hand-over to a different action, with no
                  // cooldown gap in between.
                  w_code_nxt    = w_req;
                  w_cnt_nxt     = c_HOLD_LOAD;
                  w_changed_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_COOLDOWN;
                  w_code_nxt  = 2'b00;
                  w_cnt_nxt   = c_COOL_LOAD;
               end
            end
            // When the request still equals the held code, the action
            // stays in ACTIVE with the counter parked at zero.
         end

         S_COOLDOWN: begin
            w_code_nxt = 2'b00;
            if (r_cnt != 8'd0) begin
               w_cnt_nxt = r_cnt - 8'd1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_code_nxt  = 2'b00;
            w_cnt_nxt   = 8'd0;
         end
      endcase
   end

   assign outputState = r_code;
   assign changed     = r_changed;
   assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/action_encoder.md
ACTION_ENCODER -- requirements
Module: action_encoder

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable cycles required before a filtered button level changes (range 1..255).
- REQ-002: Parameter HOLD_CYCLES, default 8, is the minimum number of cycles an encoded action is presented (range 1..255).
- REQ-003: Parameter COOLDOWN_CYCLES, default 4, is the number of idle cycles forced after an action ends (range 1..255).
- REQ-004: The port clk SHALL be an input, 1 bit wide, and serve as the single clock; all state SHALL update on its rising edge.
- REQ-005: The port rst SHALL be an input, 1 bit wide, and act as an asynchronous, active-high reset.
- REQ-006: The port inputButtons SHALL be an input, 3 bits wide, carrying raw asynchronous action requests: bit2 is the highest-priority action, bit1 is the middle action, and bit0 is the lowest.
- REQ-007: The port outputState SHALL be an output, 2 bits wide, carrying the registered action code: 2'b11 for bit2, 2'b10 for bit1, 2'b01 for bit0, and 2'b00 for none.
- REQ-008: The port changed SHALL be an output, 1 bit wide, pulsing high for one cycle in the cycle outputState takes a new non-zero code.
- REQ-009: The port busy SHALL be an output, 1 bit wide, and be high whenever the FSM is not in IDLE.

Function
- REQ-010: Each inputButtons bit SHALL pass through a 2-flop synchronizer before any other use.
- REQ-011: Each synchronized bit SHALL have a filtered level that toggles only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle SHALL clear that bit's counter.
- REQ-012: The request code SHALL be the priority encode of the filtered levels: bit2 > bit1 > bit0, and 2'b00 when no bit is set.
- REQ-013: The FSM SHALL have exactly three states: IDLE, ACTIVE and COOLDOWN.
- REQ-014: In IDLE, outputState SHALL be 2'b00; on a non-zero request the FSM SHALL register the code, enter ACTIVE, load the hold counter with HOLD_CYCLES-1 and pulse changed.
- REQ-015: In ACTIVE, outputState SHALL remain constant and the hold counter SHALL decrement each cycle; requests SHALL NOT preempt the action before the counter reaches 0.
- REQ-016: In ACTIVE with the counter at 0 and the request equal to the held code, the FSM SHALL stay in ACTIVE with no changed pulse.
- REQ-017: In ACTIVE with the counter at 0 and a different non-zero request, the FSM SHALL switch to the new code, reload the hold counter and pulse changed, without passing through COOLDOWN.
- REQ-018: In ACTIVE with the counter at 0 and a 2'b00 request, the FSM SHALL enter COOLDOWN, drive outputState to 2'b00 and load the cooldown counter with COOLDOWN_CYCLES-1.
- REQ-019: In COOLDOWN, requests SHALL be ignored; when the counter reaches 0 the FSM SHALL return to IDLE, and a request still present SHALL then be accepted on the following cycle.
- REQ-020: The latency from the first clk edge that samples a stable raw change to the outputState update SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles with debounce enabled, and 3 cycles without it.
- REQ-021: Simultaneous requests SHALL resolve by priority only; lower-priority requests SHALL NOT be queued.
- REQ-022: The changed output SHALL never be high while outputState is 2'b00.

Reset
- REQ-023: Assertion of rst SHALL immediately clear the synchronizers, filtered levels, all counters, outputState (2'b00), changed (0) and busy (0), and force the FSM to IDLE, including in the middle of an action.
- REQ-024: After rst deasserts, buttons already held SHALL be treated as new requests and be subject to the full latency of REQ-020.

Configuration
- REQ-025: With ACTION_ENCODER_DEBOUNCE_EN defined, the debounce filter of REQ-011 SHALL be compiled in.
- REQ-026: Without ACTION_ENCODER_DEBOUNCE_EN, the filtered level SHALL equal the synchronized level, DEBOUNCE_CYCLES SHALL be ignored, and no filter counters SHALL exist.

Verification (defaults, macro defined unless stated)
- REQ-027: Raise inputButtons=3'b001 and hold it -> outputState=2'b01 and a one-cycle changed pulse on the 7th edge, with busy going high in the same cycle.
- REQ-028: Raise inputButtons=3'b011 simultaneously -> outputState=2'b10; bit0 is never encoded while bit1 is held.
- REQ-029: Apply 3'b001, then switch to 3'b100 two cycles after the action starts -> 2'b01 is held for 8 cycles, then 2'b11 appears directly with changed and no 2'b00 cycle in between.
- REQ-030: Apply a 3-cycle glitch on bit2 -> no output change; with the macro undefined, the same glitch produces 2'b11 after 3 cycles and holds it for 8 cycles.
- REQ-031: Release 3'b010 after the hold expires and immediately press 3'b001 -> 4 cycles of 2'b00 with busy=1, then IDLE, then 2'b01 is accepted.
- REQ-032: Assert rst for 1 cycle in the middle of ACTIVE -> outputState=2'b00, busy=0 and changed=0 immediately, without waiting for a clk edge.
